muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit; successor to the separate fixed-32-bit Mult and Div blocks in the multicycle CPU.
- Executes MULT, MULTU, DIV and DIVU on one shared shift/add-subtract datapath.
- Results go to internal HI/LO registers and are exposed to the srcData mux (mfhi/mflo).
- The control unit launches an operation with a start/done handshake and receives a divide-by-zero flag for the exception path.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_unit_if.sv | 36 +++
 rtl/muldiv_sign_fix.sv | 22 ++
 rtl/muldiv_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared definitions for the iterative multiply/divide unit:
//             operation encodings, FSM state type and counter sizing.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation encodings as presented on the op bus by the control unit.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Iteration counter width for the default 32-bit datapath.
    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Counter width for an arbitrary operand width (counts 0..width-1).
    function automatic int cntWidth(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // MULT and DIV are the signed flavours; bit 0 clear marks them.
    function automatic logic isSignedOp(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_if
//  Purpose  : Launch/complete handshake and result bus between the control
//             unit (master) and the multiply/divide unit (slave).
//  Signals  : start, op, a, b      master -> slave
//             busy, done, div0     slave  -> master
//             hi, lo               slave  -> master (HI/LO registers)
//  Revision : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div0, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sign_fix
//  Purpose  : Conditional two's-complement negation. Used both to take
//             operand magnitudes at launch and to restore result signs.
//  Ports    : i_neg    1      negate when high
//             i_value  WIDTH  input value
//             o_value  WIDTH  i_value or -i_value
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);
    assign o_value = i_neg ? -i_value : i_value;
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative MULT/MULTU/DIV/DIVU on one shared datapath.
//             Magnitudes are processed unsigned (shift-add multiply,
//             restoring divide, one bit per cycle), then signs are fixed up.
//  Ports    : clk    rising-edge clock
//             rst_n  asynchronous active-low reset
//             bus    muldiv_unit_if slave: start/op/a/b in,
//                    busy/done/div0/hi/lo out
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int                 C_CNT_W = cntWidth(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

    state_e               r_state;
    state_e               w_nextState;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_isDiv;
    logic                 r_signA;
    logic                 r_signB;
    logic                 r_div0;
    logic                 r_div0Pend;
    logic [WIDTH-1:0]     r_opnd;   // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0]   r_acc;    // mul: {partial product, multiplier}; div: low half dividend -> quotient
    logic [WIDTH-1:0]     r_rem;    // partial remainder, always < divisor
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    // ------------------------------------------------------------------
    // Launch decode
    // ------------------------------------------------------------------
    logic             w_signedOp;
    logic             w_signA;
    logic             w_signB;
    logic             w_opDiv;
    logic             w_byZero;
    logic             w_launch;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;

    assign w_signedOp = SIGNED_EN && isSignedOp(bus.op);
    assign w_signA    = w_signedOp & bus.a[WIDTH-1];
    assign w_signB    = w_signedOp & bus.b[WIDTH-1];
    assign w_opDiv    = bus.op[1];
    assign w_byZero   = w_opDiv && (bus.b == '0);
    // A divide-by-zero waits one idle cycle before DONE; starts are ignored then.
    assign w_launch   = bus.start && !r_div0Pend &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_absA (
        .i_neg   (w_signA),
        .i_value (bus.a),
        .o_value (w_absA)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_absB (
        .i_neg   (w_signB),
        .i_value (bus.b),
        .o_value (w_absB)
    );

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH:0]     w_divDiff;
    logic               w_divFits;

    // Add multiplicand into the upper half when the current multiplier bit
    // is set, then shift the whole accumulator right (carry enters the top).
    assign w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mulNext  = {w_mulSum, r_acc[WIDTH-1:1]};

    // Restoring division: bring in the next dividend bit, trial-subtract.
    assign w_divShift = {r_rem, r_acc[WIDTH-1]};
    assign w_divDiff  = w_divShift - {1'b0, r_opnd};
    assign w_divFits  = ~w_divDiff[WIDTH];

    // ------------------------------------------------------------------
    // Sign restoration
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prodFixed;
    logic [WIDTH-1:0]   w_quoFixed;
    logic [WIDTH-1:0]   w_remFixed;

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fixProd (
        .i_neg   (r_signA ^ r_signB),
        .i_value (r_acc),
        .o_value (w_prodFixed)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fixQuo (
        .i_neg   (r_signA ^ r_signB),
        .i_value (r_acc[WIDTH-1:0]),
        .o_value (w_quoFixed)
    );

    // Remainder follows the dividend's sign.
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fixRem (
        .i_neg   (r_signA),
        .i_value (r_rem),
        .o_value (w_remFixed)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_div0Pend) begin
                    w_nextState = ST_DONE;
                end else if (bus.start && !w_byZero) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == C_LAST) begin
                    w_nextState = ST_FIX;
                end
            end
            ST_FIX: begin
                w_nextState = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start && !w_byZero) begin
                    w_nextState = ST_RUN;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = (r_state == ST_RUN) || (r_state == ST_FIX);
        bus.done = (r_state == ST_DONE);
        bus.div0 = (r_state == ST_DONE) && r_div0;
        bus.hi   = r_hi;
        bus.lo   = r_lo;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_isDiv    <= 1'b0;
            r_signA    <= 1'b0;
            r_signB    <= 1'b0;
            r_div0     <= 1'b0;
            r_div0Pend <= 1'b0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_div0Pend <= w_launch && w_byZero;
            if (w_launch) begin
                r_cnt   <= '0;
                r_isDiv <= w_opDiv;
                r_signA <= w_signA;
                r_signB <= w_signB;
                r_div0  <= w_byZero;
                r_rem   <= '0;
                if (w_opDiv) begin
                    r_acc  <= {{WIDTH{1'b0}}, w_absA};
                    r_opnd <= w_absB;
                end else begin
                    r_acc  <= {{WIDTH{1'b0}}, w_absB};
                    r_opnd <= w_absA;
                end
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + C_CNT_W'(1);
                if (r_isDiv) begin
                    r_rem            <= w_divFits ? w_divDiff[WIDTH-1:0] : w_divShift[WIDTH-1:0];
                    r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_divFits};
                end else begin
                    r_acc <= w_mulNext;
                end
            end else if (r_state == ST_FIX) begin
                if (r_isDiv) begin
                    r_hi <= w_remFixed;
                    r_lo <= w_quoFixed;
                end else begin
                    r_hi <= w_prodFixed[2*WIDTH-1:WIDTH];
                    r_lo <= w_prodFixed[WIDTH-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit. Two instances share the
//             stimulus: one with signed ops honoured, one with them disabled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    // Reference HI/LO state for each instance (signed / unsigned-only).
    logic [31:0] refHi, refLo, refHi2, refLo2;

    muldiv_unit_if #(.WIDTH(32)) bus  ();
    muldiv_unit_if #(.WIDTH(32)) bus2 ();

    muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b0)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference computed from the operation definitions.
    function automatic void refCalc(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input bit sEn,
                                    output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, sq, sr;
        logic [63:0] v;
        bit sgn;
        sgn = sEn && !op[0];
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!op[1]) begin
            sq = sa * sb;
            v  = sq;
            hi = v[63:32];
            lo = v[31:0];
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            v  = sq;
            lo = v[31:0];
            v  = sr;
            hi = v[31:0];
        end
    endfunction

    // HI/LO are only rewritten by a completed, non-div-by-zero operation.
    task automatic refStep(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!(op[1] && b == 32'd0)) begin
            refCalc(op, a, b, 1'b1, refHi, refLo);
            refCalc(op, a, b, 1'b0, refHi2, refLo2);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = s; bus.op  = op; bus.a  = a; bus.b  = b;
        bus2.start = s; bus2.op = op; bus2.a = a; bus2.b = b;
    endtask

    // Launch one operation, then scramble operands to show they were captured.
    // lat = number of edges after the start edge until done is seen.
    task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic [31:0] hi2, output logic [31:0] lo2,
                        output logic d0, output logic d02,
                        output int lat, output int busyN, output logic doneAfter);
        hi = '0; lo = '0; hi2 = '0; lo2 = '0; d0 = 1'b0; d02 = 1'b0;
        lat = -1; busyN = 0; doneAfter = 1'b1;
        @(negedge clk);
        drive(1'b1, op, a, b);
        @(posedge clk);
        #1;
        drive(1'b0, 2'($urandom), $urandom, $urandom);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.busy) busyN++;
            if (bus.done) begin
                lat = c;
                hi = bus.hi; lo = bus.lo; hi2 = bus2.hi; lo2 = bus2.lo;
                d0 = bus.div0; d02 = bus2.div0;
                break;
            end
        end
        if (lat >= 0) begin
            @(negedge clk);
            doneAfter = bus.done | bus.div0;
        end
        refStep(op, a, b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        #12;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.div0 !== 1'b0) begin bad++; $display("FAIL reset_div0: got %b want 0", bus.div0); end
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        refHi = '0; refLo = '0; refHi2 = '0; refLo2 = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mult_signed();
        logic [31:0] hi, lo, hi2, lo2; logic d0, d02, da; int lat, bn;
        doOp(2'b00, 32'hFFFFFFFD, 32'd7, hi, lo, hi2, lo2, d0, d02, lat, bn, da);
        total++; if (lat !== 33) begin bad++; $display("FAIL mult_latency: got %0d want 33", lat); end
        total++; if (bn !== 33) begin bad++; $display("FAIL mult_busy_cycles: got %0d want 33", bn); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        total++; if (d0 !== 1'b0) begin bad++; $display("FAIL mult_div0: got %b want 0", d0); end
        total++; if (da !== 1'b0) begin bad++; $display("FAIL mult_done_width: done still high"); end
    endtask

    task automatic test_multu();
        logic [31:0] hi, lo, hi2, lo2; logic d0, d02, da; int lat, bn;
        doOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, hi, lo, hi2, lo2, d0, d02, lat, bn, da);
        total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL multu: got %h%h want fffffffe00000001", hi, lo); end
        total++; if ({hi2, lo2} !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL multu_nosign: got %h%h want fffffffe00000001", hi2, lo2); end
        doOp(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, hi, lo, hi2, lo2, d0, d02, lat, bn, da);
        total++; if ({hi, lo} !== 64'h00000000_00000001) begin bad++; $display("FAIL mult_m1m1: got %h%h want 0000000000000001", hi, lo); end
        total++; if ({hi2, lo2} !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL mult_as_multu: got %h%h want fffffffe00000001", hi2, lo2); end
    endtask

    task automatic test_div();
        logic [31:0] hi, lo, hi2, lo2; logic d0, d02, da; int lat, bn;
        doOp(2'b10, 32'hFFFFFFF9, 32'd2, hi, lo, hi2, lo2, d0, d02, lat, bn, da);
        total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_quot: got %h want fffffffd", lo); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_rem: got %h want ffffffff", hi); end
        total++; if (lat !== 33) begin bad++; $display("FAIL div_latency: got %0d want 33", lat); end
        total++; if ({hi2, lo2} !== 64'h00000001_7FFFFFFC) begin bad++; $display("FAIL div_as_divu: got %h/%h want 00000001/7ffffffc", hi2, lo2); end
        doOp(2'b11, 32'hFFFFFFF9, 32'd2, hi, lo, hi2, lo2, d0, d02, lat, bn, da);
        total++; if ({hi, lo} !== 64'h00000001_7FFFFFFC) begin bad++; $display("FAIL divu: got %h/%h want 00000001/7ffffffc", hi, lo); end
    endtask

    task automatic test_div0();
        logic [31:0] hi, lo, hi2, lo2; logic d0, d02, da; int lat, bn;
        doOp(2'b11, 32'h2211, 32'h100, hi, lo, hi2, lo2, d0, d02, lat, bn, da);
        total++; if ({hi, lo} !== 64'h00000011_00000022) begin bad++; $display("FAIL div0_preload: got %h/%h want 11/22", hi, lo); end
        doOp(2'b11, 32'd5, 32'd0, hi, lo, hi2, lo2, d0, d02, lat, bn, da);
        total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency: got %0d want 1", lat); end
        total++; if (d0 !== 1'b1 || d02 !== 1'b1) begin bad++; $display("FAIL div0_flag: got %b%b want 11", d0, d02); end
        total++; if (bn !== 0) begin bad++; $display("FAIL div0_busy: got %0d cycles want 0", bn); end
        total++; if (da !== 1'b0) begin bad++; $display("FAIL div0_pulse_width: done/div0 still high"); end
        total++; if ({hi, lo} !== 64'h00000011_00000022) begin bad++; $display("FAIL div0_hold: got %h/%h want 11/22", hi, lo); end
        total++; if ({hi2, lo2} !== 64'h00000011_00000022) begin bad++; $display("FAIL div0_hold2: got %h/%h want 11/22", hi2, lo2); end
    endtask

    task automatic test_overflow_restart();
        logic [31:0] hi, lo, hi2, lo2; logic d0; int nDone, lat;
        hi = '0; lo = '0; hi2 = '0; lo2 = '0; d0 = 1'b1; nDone = 0; lat = -1;
        @(negedge clk);
        drive(1'b1, 2'b10, 32'h80000000, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 2'b01, 32'd3, 32'd3);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b01, 32'd0, 32'd0);
        for (int c = 6; c < 56; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (nDone == 0) begin
                    lat = c; hi = bus.hi; lo = bus.lo; hi2 = bus2.hi; lo2 = bus2.lo; d0 = bus.div0;
                end
                nDone++;
            end
        end
        refStep(2'b10, 32'h80000000, 32'hFFFFFFFF);
        total++; if (nDone !== 1) begin bad++; $display("FAIL restart_ignored: got %0d dones want 1", nDone); end
        total++; if (lat !== 33) begin bad++; $display("FAIL ovf_latency: got %0d want 33", lat); end
        total++; if ({hi, lo} !== 64'h00000000_80000000) begin bad++; $display("FAIL ovf_result: got %h/%h want 00000000/80000000", hi, lo); end
        total++; if (d0 !== 1'b0) begin bad++; $display("FAIL ovf_div0: got %b want 0", d0); end
        total++; if ({hi2, lo2} !== 64'h80000000_00000000) begin bad++; $display("FAIL ovf_divu: got %h/%h want 80000000/00000000", hi2, lo2); end
    endtask

    task automatic test_async_reset();
        logic [31:0] hi, lo, hi2, lo2; logic d0, d02, da; int lat, bn;
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h12345, 32'h6789);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0 || bus.div0 !== 1'b0) begin bad++; $display("FAIL areset_done: got %b%b want 00", bus.done, bus.div0); end
        total++; if ({bus.hi, bus.lo} !== 64'd0) begin bad++; $display("FAIL areset_hilo: got %h/%h want 0/0", bus.hi, bus.lo); end
        total++; if ({bus2.hi, bus2.lo} !== 64'd0) begin bad++; $display("FAIL areset_hilo2: got %h/%h want 0/0", bus2.hi, bus2.lo); end
        refHi = '0; refLo = '0; refHi2 = '0; refLo2 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        doOp(2'b00, 32'd6, 32'd7, hi, lo, hi2, lo2, d0, d02, lat, bn, da);
        total++; if ({hi, lo} !== 64'd42) begin bad++; $display("FAIL areset_after: got %h/%h want 0/2a", hi, lo); end
        total++; if (lat !== 33) begin bad++; $display("FAIL areset_latency: got %0d want 33", lat); end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] hi, lo, hi2, lo2, a, b; logic [1:0] op; logic d0, d02, da, z; int lat, bn;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            z  = op[1] && (b == 32'd0);
            doOp(op, a, b, hi, lo, hi2, lo2, d0, d02, lat, bn, da);
            total++; if ({hi, lo} !== {refHi, refLo}) begin bad++; $display("FAIL rand_signed op=%0d a=%h b=%h: got %h/%h want %h/%h", op, a, b, hi, lo, refHi, refLo); end
            total++; if ({hi2, lo2} !== {refHi2, refLo2}) begin bad++; $display("FAIL rand_unsigned op=%0d a=%h b=%h: got %h/%h want %h/%h", op, a, b, hi2, lo2, refHi2, refLo2); end
            total++; if (lat !== (z ? 1 : 33)) begin bad++; $display("FAIL rand_latency op=%0d b=%h: got %0d want %0d", op, b, lat, z ? 1 : 33); end
            total++; if (d0 !== z || d02 !== z) begin bad++; $display("FAIL rand_div0 op=%0d b=%h: got %b%b want %b", op, b, d0, d02, z); end
        end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu();
        test_div();
        test_div0();
        test_overflow_restart();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
